// File: rtl/atconv_pkg.sv
// Shared types and constants for the atrous-convolution engine.
// Kernel and bias are Q.4 fixed point at 13-bit width.
package atconv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_POOL,
    S_DONE
  } state_t;

  localparam int KERNEL_W = 13;

  // 3x3 kernel in row-major order:
  // -1/16 -1/8 -1/16 / -1/4 1 -1/4 / -1/16 -1/8 -1/16
  localparam logic signed [KERNEL_W-1:0] KERNEL [9] = '{
    13'h1FFF, 13'h1FFE, 13'h1FFF,
    13'h1FFC, 13'h0010, 13'h1FFC,
    13'h1FFF, 13'h1FFE, 13'h1FFF
  };

  // -0.75
  localparam logic signed [KERNEL_W-1:0] BIAS = 13'h1FF4;

  // Round a fixed-point value up to the next integer when any fraction bit is set.
  function automatic int round_up(input int v, input int frac);
    int mask;
    mask = (1 << frac) - 1;
    if ((v & mask) != 0) return (v & ~mask) + (1 << frac);
    return v;
  endfunction

endpackage

// File: rtl/atconv_addr_gen.sv
// Offset-plus-clamp address generator: (base + offset) clamped to 0..W-1 on
// each axis, packed row-major. Used for both convolution taps and pool reads.
module atconv_addr_gen
  import atconv_pkg::*;
#(
  parameter int IMG_LOG2 = 6
) (
  input  logic [IMG_LOG2-1:0]   base_y,
  input  logic [IMG_LOG2-1:0]   base_x,
  input  logic signed [3:0]     off_y,
  input  logic signed [3:0]     off_x,
  output logic [2*IMG_LOG2-1:0] addr
);

  localparam int SW = IMG_LOG2 + 2;

  logic signed [SW-1:0]  sum_y, sum_x;
  logic [IMG_LOG2-1:0]   cl_y, cl_x;

  // Signed sum with two guard bits: MSB flags underflow, next bit flags >= W.
  always_comb begin
    sum_y = $signed({2'b00, base_y}) + SW'(off_y);
    sum_x = $signed({2'b00, base_x}) + SW'(off_x);
    if (sum_y[SW-1])      cl_y = '0;
    else if (sum_y[SW-2]) cl_y = '1;
    else                  cl_y = sum_y[IMG_LOG2-1:0];
    if (sum_x[SW-1])      cl_x = '0;
    else if (sum_x[SW-2]) cl_x = '1;
    else                  cl_x = sum_x[IMG_LOG2-1:0];
    addr = {cl_y, cl_x};
  end

endmodule

// File: rtl/atconv_param.sv
// Parametrised 3x3 dilated convolution (bias, ReLU, saturate) into layer 0,
// followed by 2x2 max-pool with round-up into layer 1.
// Build option: ATCONV_POOL_EN enables the pooling stage; without it the frame
// ends after convolution.
module atconv_param
  import atconv_pkg::*;
#(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 13,
  parameter int FRAC_W   = 4,
  parameter int ACC_W    = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic [1:0]            dilation,
  output logic                  busy,
  output logic                  done,
  output logic [2*IMG_LOG2-1:0] iaddr,
  input  logic [DATA_W-1:0]     idata,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DATA_W-1:0]     cdata_wr,
  output logic                  crd,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  input  logic [DATA_W-1:0]     cdata_rd,
  output logic                  csel
);

  localparam int AW = 2 * IMG_LOG2;
  localparam logic [AW-1:0] LAST_PIX = '1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);

  state_t               state;
  logic [1:0]           d_lat;
  logic [AW-1:0]        pix;
  logic [3:0]           tap;
  logic signed [ACC_W-1:0] acc;

  logic signed [3:0]    d_pos, d_neg, tap_dy, tap_dx;
  logic signed [DATA_W-1:0]   weight;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    term, conv_sum;
  logic [DATA_W-1:0]    conv_val;

  logic [IMG_LOG2-1:0]  ag_y, ag_x;
  logic signed [3:0]    ag_dy, ag_dx;
  logic [AW-1:0]        ag_addr;

`ifdef ATCONV_POOL_EN
  localparam logic [AW-3:0] LAST_POOL = '1;
  logic [AW-3:0]            pidx;
  logic [2:0]               phase;
  logic signed [DATA_W-1:0] pmax, rd_val;
  logic [DATA_W-1:0]        pool_out;
`else
  logic unused_rd;
  assign unused_rd = ^cdata_rd;
`endif

  // Tap offsets: kernel row/column minus one, scaled by the latched dilation.
  always_comb begin
    d_pos = {2'b00, d_lat};
    d_neg = -d_pos;
    case (tap)
      4'd0, 4'd1, 4'd2: tap_dy = d_neg;
      4'd3, 4'd4, 4'd5: tap_dy = '0;
      default:          tap_dy = d_pos;
    endcase
    case (tap)
      4'd0, 4'd3, 4'd6: tap_dx = d_neg;
      4'd1, 4'd4, 4'd7: tap_dx = '0;
      default:          tap_dx = d_pos;
    endcase
  end

  // Address generator inputs: convolution taps, or pool window reads in POOL.
  always_comb begin
    ag_y  = pix[AW-1:IMG_LOG2];
    ag_x  = pix[IMG_LOG2-1:0];
    ag_dy = tap_dy;
    ag_dx = tap_dx;
`ifdef ATCONV_POOL_EN
    if (state == S_POOL) begin
      ag_y  = {pidx[AW-3:IMG_LOG2-1], 1'b0};
      ag_x  = {pidx[IMG_LOG2-2:0], 1'b0};
      ag_dy = {3'b000, phase[1]};
      ag_dx = {3'b000, phase[0]};
    end
`endif
  end

  atconv_addr_gen #(.IMG_LOG2(IMG_LOG2)) u_addr_gen (
    .base_y (ag_y),
    .base_x (ag_x),
    .off_y  (ag_dy),
    .off_x  (ag_dx),
    .addr   (ag_addr)
  );

  // Per-tap product, final sum with bias, ReLU and positive saturation.
  always_comb begin
    weight   = DATA_W'(KERNEL[tap]);
    prod     = (2*DATA_W)'($signed(idata)) * (2*DATA_W)'(weight);
    term     = ACC_W'(prod >>> FRAC_W);
    conv_sum = acc + term + ACC_W'(BIAS);
    if (conv_sum[ACC_W-1])       conv_val = '0;
    else if (conv_sum > SAT_MAX) conv_val = {1'b0, {(DATA_W-1){1'b1}}};
    else                         conv_val = conv_sum[DATA_W-1:0];
  end

`ifdef ATCONV_POOL_EN
  // Pool read value and rounded-up result of the finished 2x2 window.
  always_comb begin
    rd_val   = $signed(cdata_rd);
    pool_out = DATA_W'(round_up(int'(pmax), FRAC_W));
  end
`endif

  // Frame sequencer: counters, accumulator and running max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      d_lat <= '0;
      pix   <= '0;
      tap   <= '0;
      acc   <= '0;
`ifdef ATCONV_POOL_EN
      pidx  <= '0;
      phase <= '0;
      pmax  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          pix <= '0;
          tap <= '0;
          acc <= '0;
`ifdef ATCONV_POOL_EN
          pidx  <= '0;
          phase <= '0;
`endif
          if (ready) begin
            d_lat <= (dilation == 2'd0) ? 2'd1 : dilation;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          if (tap == 4'd8) begin
            tap <= '0;
            acc <= '0;
            pix <= pix + AW'(1);
            if (pix == LAST_PIX) begin
`ifdef ATCONV_POOL_EN
              state <= S_POOL;
`else
              state <= S_DONE;
`endif
            end
          end else begin
            tap <= tap + 4'd1;
            acc <= acc + term;
          end
        end
`ifdef ATCONV_POOL_EN
        S_POOL: begin
          if (phase == 3'd4) begin
            phase <= '0;
            pidx  <= pidx + (AW-2)'(1);
            if (pidx == LAST_POOL) state <= S_DONE;
          end else begin
            phase <= phase + 3'd1;
            if (phase == 3'd0 || rd_val > pmax) pmax <= rd_val;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side strobes and addresses decoded from the sequencer state.
  always_comb begin
    busy     = (state == S_CONV) || (state == S_POOL);
    done     = (state == S_DONE);
    iaddr    = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    csel     = 1'b0;
    if (state == S_CONV) begin
      iaddr = ag_addr;
      if (tap == 4'd8) begin
        cwr      = 1'b1;
        caddr_wr = pix;
        cdata_wr = conv_val;
      end
    end
`ifdef ATCONV_POOL_EN
    if (state == S_POOL) begin
      if (phase == 3'd4) begin
        cwr      = 1'b1;
        csel     = 1'b1;
        caddr_wr = AW'(pidx);
        cdata_wr = pool_out;
      end else begin
        crd      = 1'b1;
        caddr_rd = ag_addr;
      end
    end
`endif
  end

endmodule

// File: tb/tb_atconv_param.sv
// Self-checking bench for atconv_param at W=16 with image ROM and layer RAM models.
module tb_atconv_param;

  localparam int LG    = 4;
  localparam int W     = 16;
  localparam int NPIX  = W * W;
  localparam int NPOOL = NPIX / 4;
  localparam int DW    = 13;
  localparam int CONV_CYC = NPIX * 9;
`ifdef ATCONV_POOL_EN
  localparam int POOL_CYC = NPOOL * 5;
  localparam int POOL_WR  = NPOOL;
  localparam int POOL_RD  = NPIX;
`else
  localparam int POOL_CYC = 0;
  localparam int POOL_WR  = 0;
  localparam int POOL_RD  = 0;
`endif
  localparam logic [DW-1:0] SENTINEL = 13'h1555;

  logic            clk = 1'b0;
  logic            reset;
  logic            ready;
  logic [1:0]      dilation;
  logic            busy, done, cwr, crd, csel;
  logic [2*LG-1:0] iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0]   idata, cdata_wr, cdata_rd;

  logic [DW-1:0] img [NPIX];
  logic [DW-1:0] l0  [NPIX];
  logic [DW-1:0] l1  [NPOOL];

  int  exp0 [NPIX];
  int  exp1 [NPOOL];
  bit  pool_ok [NPOOL];
  int  wk [9] = '{-1, -2, -1, -4, 16, -4, -1, -2, -1};

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_wr0 = 0, n_wr1 = 0, n_rd = 0;

  atconv_param #(
    .IMG_LOG2 (LG),
    .DATA_W   (DW),
    .FRAC_W   (4),
    .ACC_W    (18)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .dilation (dilation),
    .busy     (busy),
    .done     (done),
    .iaddr    (iaddr),
    .idata    (idata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  assign idata    = img[iaddr];
  assign cdata_rd = l0[caddr_rd];

  always @(posedge clk) begin
    if (cwr) begin
      if (csel) l1[caddr_wr[5:0]] <= cdata_wr;
      else      l0[caddr_wr]      <= cdata_wr;
    end
  end

  always @(negedge clk) begin
    if (done)         n_done++;
    if (cwr && !csel) n_wr0++;
    if (cwr && csel)  n_wr1++;
    if (crd)          n_rd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > W - 1) return W - 1;
    return v;
  endfunction

  // Reference: arithmetic straight from the convolution/pool definition.
  task automatic build_ref(input int d);
    int dd, acc, yy, xx, p, m, a, b;
    dd = (d == 0) ? 1 : d;
    for (int y = 0; y < W; y++) begin
      for (int x = 0; x < W; x++) begin
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          yy  = clampi(y + (k / 3 - 1) * dd);
          xx  = clampi(x + (k % 3 - 1) * dd);
          p   = int'($signed(img[yy * W + xx]));
          acc = acc + ((p * wk[k]) >>> 4);
        end
        acc = acc - 12;
        if (acc < 0) acc = 0;
        if (acc > 4095) acc = 4095;
        exp0[y * W + x] = acc;
      end
    end
    for (int py = 0; py < W / 2; py++) begin
      for (int px = 0; px < W / 2; px++) begin
        a = exp0[(2 * py) * W + 2 * px];
        b = exp0[(2 * py) * W + 2 * px + 1];
        m = (a > b) ? a : b;
        a = exp0[(2 * py + 1) * W + 2 * px];
        b = exp0[(2 * py + 1) * W + 2 * px + 1];
        if (a > m) m = a;
        if (b > m) m = b;
        pool_ok[py * (W / 2) + px] = (m <= 4080);
        exp1[py * (W / 2) + px] = ((m % 16) != 0) ? (m - (m % 16) + 16) : m;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++)  l0[i] = SENTINEL;
    for (int i = 0; i < NPOOL; i++) l1[i] = SENTINEL;
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_l0[%0d]", name, i), 32'(l0[i]), exp0[i]);
`ifdef ATCONV_POOL_EN
    for (int i = 0; i < NPOOL; i++)
      if (pool_ok[i]) chk($sformatf("%s_l1[%0d]", name, i), 32'(l1[i]), exp1[i]);
`endif
  endtask

  // Start a frame, optionally pulse ready mid-frame, and time the done pulse.
  task automatic run_frame(input string name, input logic [1:0] d, input int poke_at);
    int lat, d0, w0, w1, r0;
    d0 = n_done; w0 = n_wr0; w1 = n_wr1; r0 = n_rd;
    @(negedge clk);
    ready = 1'b1;
    dilation = d;
    @(posedge clk); #1;
    chk({name, "_busy_rise"}, 32'(busy), 1);
    ready = 1'b0;
    dilation = 2'($urandom);
    lat = 0;
    while (!done && lat < CONV_CYC + POOL_CYC + 50) begin
      ready = (lat == poke_at);
      @(posedge clk); #1;
      lat++;
    end
    ready = 1'b0;
    chk({name, "_latency"}, lat, CONV_CYC + POOL_CYC);
    chk({name, "_busy_at_done"}, 32'(busy), 0);
    @(posedge clk); #1;
    chk({name, "_done_width"}, 32'(done), 0);
    chk({name, "_busy_after"}, 32'(busy), 0);
    chk({name, "_done_count"}, n_done - d0, 1);
    chk({name, "_l0_writes"}, n_wr0 - w0, NPIX);
    chk({name, "_l1_writes"}, n_wr1 - w1, POOL_WR);
    chk({name, "_reads"}, n_rd - r0, POOL_RD);
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    dilation = 2'd0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cwr", 32'(cwr), 0);
    chk("rst_crd", 32'(crd), 0);
    chk("rst_csel", 32'(csel), 0);
    chk("rst_iaddr", 32'(iaddr), 0);
    chk("rst_caddr_wr", 32'(caddr_wr), 0);
    chk("rst_caddr_rd", 32'(caddr_rd), 0);
    chk("rst_cdata_wr", 32'(cdata_wr), 0);
    @(negedge clk);
    reset = 1'b0;

    // Flat 16.0, D=2: kernel sums to zero, bias then ReLU gives 0 everywhere.
    for (int i = 0; i < NPIX; i++) img[i] = 13'h100;
    clear_mem();
    run_frame("flat", 2'd2, -1);
    build_ref(2);
    chk("flat_l0_0", 32'(l0[0]), 0);
`ifdef ATCONV_POOL_EN
    chk("flat_l1_0", 32'(l1[0]), 0);
`endif
    check_mem("flat");

    // Impulse 1.0 at (10,10), D=2.
    for (int i = 0; i < NPIX; i++) img[i] = '0;
    img[10 * W + 10] = 13'h010;
    clear_mem();
    run_frame("imp2", 2'd2, -1);
    build_ref(2);
    chk("imp2_center", 32'(l0[10 * W + 10]), 32'h004);
    chk("imp2_x12", 32'(l0[10 * W + 12]), 32'h000);
`ifdef ATCONV_POOL_EN
    chk("imp2_pool", 32'(l1[5 * (W / 2) + 5]), 32'h010);
`endif
    check_mem("imp2");

    // Same impulse, D=1.
    clear_mem();
    run_frame("imp1", 2'd1, -1);
    build_ref(1);
    chk("imp1_x11", 32'(l0[10 * W + 11]), 32'h000);
    chk("imp1_center", 32'(l0[10 * W + 10]), 32'h004);
    check_mem("imp1");

    // Corner 4.0 at (0,0), D=2: padding folds taps (0,0),(0,1),(1,0),(1,1)
    // onto the pixel: 4.0*(1-1/16-1/8-1/4) - 0.75 = 1.5.
    for (int i = 0; i < NPIX; i++) img[i] = '0;
    img[0] = 13'h040;
    clear_mem();
    run_frame("corner", 2'd2, -1);
    build_ref(2);
    chk("corner_l0_0", 32'(l0[0]), 32'h018);
    check_mem("corner");

    // Full-range random image, D=3, with a ready pulse mid-frame.
    for (int i = 0; i < NPIX; i++) img[i] = 13'($urandom);
    clear_mem();
    run_frame("rnd3", 2'd3, 500);
    build_ref(3);
    check_mem("rnd3");

    // Moderate random image, dilation 0 behaves as 1.
    for (int i = 0; i < NPIX; i++) img[i] = 13'($urandom_range(0, 1023) - 512);
    clear_mem();
    run_frame("rnd0", 2'd0, -1);
    build_ref(0);
    check_mem("rnd0");

    // Reset at pixel 100 (y=6,x=4), tap 0 of D=2 reads (4,2).
    begin
      int d0;
      for (int i = 0; i < NPIX; i++) img[i] = 13'($urandom_range(0, 2047) - 1024);
      clear_mem();
      d0 = n_done;
      @(negedge clk);
      ready = 1'b1;
      dilation = 2'd2;
      @(posedge clk); #1;
      ready = 1'b0;
      repeat (100 * 9) @(posedge clk);
      #1;
      chk("abort_iaddr", 32'(iaddr), 4 * W + 2);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cwr", 32'(cwr), 0);
      chk("abort_done", 32'(done), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", n_done - d0, 0);
      clear_mem();
      run_frame("restart", 2'd2, -1);
      build_ref(2);
      check_mem("restart");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
